disp_scan_out: RTL and testbench

- Downstream consumer of the frame buffer's read port; generates display raster timing.
- Issues active-low per-pixel read requests to the frame buffer and realigns the returned pixel data with hsync, vsync and data-enable.
- Emits a registered pixel stream for the display PHY.
- Runs in the frame buffer's read clock domain; single clock.

---
 rtl/disp_scan_out.sv | 148 ++++++++++++++
 tb/tb_disp_scan_out.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_out.sv
// disp_scan_out: raster timing generator that reads pixels from the frame buffer.
// Ports: clk, reset (async, active-low), enable, pix_data_in -> rd_en_l, pix_out,
//        de, hsync_l, vsync_l, frame_start, busy.
module disp_scan_out #(
  parameter int DATA_WIDTH = 32,
  parameter int H_ACTIVE   = 8,
  parameter int H_FP       = 2,
  parameter int H_SYNC     = 2,
  parameter int H_BP       = 2,
  parameter int V_ACTIVE   = 4,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 1,
  parameter int V_BP       = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] pix_data_in,
  output logic                  rd_en_l,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  de,
  output logic                  hsync_l,
  output logic                  vsync_l,
  output logic                  frame_start,
  output logic                  busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int NS = RD_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            h_last;
  logic            v_last;
  logic            run;
  logic            act0;
  logic            hs0;
  logic            vs0;
  logic            first0;
  logic [NS-1:0]   act_p;
  logic [NS-1:0]   hs_p;
  logic [NS-1:0]   vs_p;
  logic [NS-1:0]   first_p;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A stop request only takes effect at the end of a frame.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (enable) state_nxt = S_RUN;
      S_RUN: begin
        if (!enable)
          state_nxt = (h_last && v_last) ? S_IDLE : S_STOP;
      end
      S_STOP: begin
        if (enable)                state_nxt = S_RUN;
        else if (h_last && v_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    run    = (state != S_IDLE);
    act0   = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0    = run && (h_cnt >= H_SS) && (h_cnt < H_SE);
    vs0    = run && (v_cnt >= V_SS) && (v_cnt < V_SE);
    first0 = act0 && (h_cnt == '0) && (v_cnt == '0);
    busy   = run || (|act_p);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == S_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0 of the flag pipe is the same edge that issues rd_en_l.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_l <= 1'b1;
      act_p   <= '0;
      hs_p    <= '0;
      vs_p    <= '0;
      first_p <= '0;
    end else begin
      rd_en_l <= ~act0;
      act_p   <= {act_p[NS-2:0], act0};
      hs_p    <= {hs_p[NS-2:0], hs0};
      vs_p    <= {vs_p[NS-2:0], vs0};
      first_p <= {first_p[NS-2:0], first0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de          <= 1'b0;
      pix_out     <= '0;
      hsync_l     <= 1'b1;
      vsync_l     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      de          <= act_p[NS-1];
      pix_out     <= act_p[NS-1] ? pix_data_in : '0;
      hsync_l     <= ~hs_p[NS-1];
      vsync_l     <= ~vs_p[NS-1];
      frame_start <= first_p[NS-1];
    end
  end

endmodule

// File: tb/tb_disp_scan_out.sv
// tb_disp_scan_out: scan-out bench, three read latencies against a raster model.
// Ports: none (top-level bench).
module tb_disp_scan_out;

  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int FRM = HT * VT;

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        first;
    logic [31:0] data;
  } desc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] junk;
  logic [31:0] mem [32];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Raster position p of a running frame -> what must appear L+2 clocks later.
  function automatic desc_t mk(input bit on, input int p);
    desc_t d;
    int x, y;
    x = p % HT;
    y = p / HT;
    d.act   = on && x < 8 && y < 4;
    d.hs    = on && x >= 10 && x < 12;
    d.vs    = on && y == 5;
    d.first = d.act && p == 0;
    d.data  = d.act ? mem[y * 8 + x] : 32'h0;
    return d;
  endfunction

  always @(posedge clk) junk <= reset ? $urandom : 32'hffff_ffff;

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic        rd_en_l, de, hsync_l, vsync_l, frame_start, busy;
    logic [31:0] pix_out, pix_data_in;
    logic        rv [8];
    logic [31:0] rdat [8];
    int          idx = 0;
    desc_t       hist [8];
    bit          m_on;
    int          pos;

    disp_scan_out #(.DATA_WIDTH(32), .RD_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pix_data_in(pix_data_in), .rd_en_l(rd_en_l), .pix_out(pix_out),
      .de(de), .hsync_l(hsync_l), .vsync_l(vsync_l),
      .frame_start(frame_start), .busy(busy)
    );

    // frame buffer: request k of a frame returns mem[k] L clocks later
    assign pix_data_in = rv[L-1] ? rdat[L-1] : junk;

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        idx = 0;
        for (int i = 0; i < 8; i++) rv[i] <= 1'b0;
      end else begin
        rv[0]   <= !rd_en_l;
        rdat[0] <= mem[idx];
        if (!rd_en_l) idx = (idx + 1) % 32;
        for (int i = 1; i < 8; i++) begin
          rv[i]   <= rv[i-1];
          rdat[i] <= rdat[i-1];
        end
      end
    end

    always @(posedge clk) begin
      if (!reset) begin
        m_on = 0;
        pos  = 0;
        for (int i = 0; i < 8; i++) hist[i] = '0;
      end else begin
        if (!m_on) begin
          if (enable) begin
            m_on = 1;
            pos  = 0;
          end
        end else if (pos == FRM - 1) begin
          if (enable) pos = 0;
          else        m_on = 0;
        end else begin
          pos++;
        end
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = mk(m_on, pos);
      end
    end

    always @(negedge clk) begin
      desc_t e;
      bit    b;
      if (!reset) begin
        check("rst_rd", rd_en_l, 1);
        check("rst_de", de, 0);
        check("rst_pix", pix_out, 0);
        check("rst_hs", hsync_l, 1);
        check("rst_vs", vsync_l, 1);
        check("rst_fs", frame_start, 0);
        check("rst_busy", busy, 0);
      end else begin
        e = hist[L+2];
        b = m_on;
        for (int k = 1; k <= L + 1; k++) b = b | hist[k].act;
        check("rd_en_l", rd_en_l, !hist[1].act);
        check("de", de, e.act);
        check("pix_out", pix_out, e.data);
        check("hsync_l", hsync_l, !e.hs);
        check("vsync_l", vsync_l, !e.vs);
        check("frame_start", frame_start, e.first);
        check("busy", busy, b);
      end
    end
  end

  int cyc = 0, n_rd = 0, n_de = 0, n_fs = 0, n_busy = 0, n_vs = 0, n_hs = 0;
  int fs_cyc = 0, fs_gap = 0, de_rise = 0, hs_gap = 0;
  int s_rd, s_de, s_fs, s_busy, s_vs, s_hs;
  logic [31:0] fs_pix = 32'hdead_beef;
  logic de_q = 1'b0, hs_q = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (!g_lat[0].rd_en_l) n_rd++;
      if (g_lat[0].de) n_de++;
      if (g_lat[0].busy) n_busy++;
      if (!g_lat[0].vsync_l) n_vs++;
      if (!g_lat[0].hsync_l) n_hs++;
      if (g_lat[0].frame_start) begin
        n_fs++;
        fs_gap = cyc - fs_cyc;
        fs_cyc = cyc;
        fs_pix = g_lat[0].pix_out;
      end
      if (g_lat[0].de && !de_q) de_rise = cyc;
      if (!g_lat[0].hsync_l && hs_q && cyc - de_rise < HT)
        hs_gap = cyc - de_rise;
    end
    de_q = g_lat[0].de;
    hs_q = g_lat[0].hsync_l;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic snap();
    s_rd = n_rd; s_de = n_de; s_fs = n_fs;
    s_busy = n_busy; s_vs = n_vs; s_hs = n_hs;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = (i % 8) + 16 * (i / 8);
    tick(3);
    reset  = 1'b1;
    enable = 1'b0;
    snap();
    tick(50);
    check("idle_rd", n_rd - s_rd, 0);
    check("idle_busy", n_busy - s_busy, 0);

    snap();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(120);
    check("one_rd", n_rd - s_rd, 32);
    check("one_de", n_de - s_de, 32);
    check("one_fs", n_fs - s_fs, 1);
    check("one_fs_pix", fs_pix, 0);
    check("one_busy", n_busy - s_busy, FRM);
    check("hs_after_de", hs_gap, 10);

    snap();
    enable = 1'b1;
    tick(3 * FRM);
    enable = 1'b0;
    tick(150);
    check("run3_fs", n_fs - s_fs, 3);
    check("run3_gap", fs_gap, FRM);
    check("run3_vs", n_vs - s_vs, 3 * HT);
    check("run3_hs", n_hs - s_hs, 3 * VT * 2);
    check("run3_busy", n_busy - s_busy, 3 * FRM);

    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int it = 0; it < 40; it++) begin
      enable = ($urandom_range(0, 3) != 0);
      tick($urandom_range(1, 60));
    end
    enable = 1'b0;
    tick(250);

    snap();
    enable = 1'b1;
    tick(2 * HT + 6);
    enable = 1'b0;
    tick(200);
    check("stop_de", n_de - s_de, 32);
    check("stop_fs", n_fs - s_fs, 1);
    check("stop_busy", n_busy - s_busy, FRM);

    snap();
    enable = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(40);
    enable = 1'b1;
    tick(150);
    enable = 1'b0;
    tick(250);
    check("rearm_fs", n_fs - s_fs, 3);
    check("rearm_gap", fs_gap, FRM);

    enable = 1'b1;
    tick(1 + HT + 3);
    reset = 1'b0;
    #1;
    check("arst_rd", g_lat[0].rd_en_l, 1);
    check("arst_de", g_lat[0].de, 0);
    check("arst_pix", g_lat[0].pix_out, 0);
    check("arst_hs", g_lat[0].hsync_l, 1);
    check("arst_busy", g_lat[0].busy, 0);
    tick(5);
    enable = 1'b0;
    reset  = 1'b1;
    snap();
    tick(40);
    check("post_rst_rd", n_rd - s_rd, 0);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(120);
    check("restart_rd", n_rd - s_rd, 32);
    check("restart_fs", n_fs - s_fs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
